// File: rtl/apb_ucpd_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : apb_ucpd_tx_sched
//  Purpose  : UCPD transmit scheduler. Latches message-send and hard-reset
//             requests, enforces the interframe gap against line activity,
//             arbitrates message / hard reset / incoming reception, drives the
//             core transmit enables and reports sent/discarded/aborted events.
//  Ports    : ic_clk, ic_rst (async, active-high), ucpden (enable),
//             hbit_clk_red (half-bit tick), ifrgap (required idle ticks),
//             txsend_req / txhrst_req (request pulses), rx_busy, hrst_rx,
//             tx_done (core status) -> transmit_en, tx_hrst (core enables),
//             tx_msg_sent/disc/abt, tx_hrst_sent/disc (status pulses),
//             sched_busy.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_ucpd_tx_sched #(
    parameter int unsigned GAP_W = 5
) (
    input  logic             ic_clk,
    input  logic             ic_rst,
    input  logic             ucpden,
    input  logic             hbit_clk_red,
    input  logic [GAP_W-1:0] ifrgap,
    input  logic             txsend_req,
    input  logic             txhrst_req,
    input  logic             rx_busy,
    input  logic             hrst_rx,
    input  logic             tx_done,
    output logic             transmit_en,
    output logic             tx_hrst,
    output logic             tx_msg_sent,
    output logic             tx_msg_disc,
    output logic             tx_msg_abt,
    output logic             tx_hrst_sent,
    output logic             tx_hrst_disc,
    output logic             sched_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_TX_MSG  = 2'd2,
        S_TX_HRST = 2'd3
    } state_t;

    localparam logic [GAP_W-1:0] C_GAP_MAX = '1;

    state_t           state_q, state_d;
    logic             pend_msg_q, pend_msg_d;
    logic             pend_hrst_q, pend_hrst_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             msg_sent_q, msg_sent_d;
    logic             msg_disc_q, msg_disc_d;
    logic             msg_abt_q, msg_abt_d;
    logic             hrst_sent_q, hrst_sent_d;
    logic             hrst_disc_q, hrst_disc_d;

    logic             in_tx;
    logic             gap_ok;

    assign in_tx  = (state_q == S_TX_MSG) || (state_q == S_TX_HRST);
    assign gap_ok = (gap_q >= ifrgap);

    // Idle-time counter in half-bit ticks; any line or transmit activity
    // restarts the gap measurement.
    always_comb begin
        gap_d = gap_q;
        if (!ucpden || rx_busy || in_tx || tx_done) begin
            gap_d = '0;
        end else if (hbit_clk_red && (gap_q != C_GAP_MAX)) begin
            gap_d = gap_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_msg_d  = pend_msg_q;
        pend_hrst_d = pend_hrst_q;
        msg_sent_d  = 1'b0;
        msg_disc_d  = 1'b0;
        msg_abt_d   = 1'b0;
        hrst_sent_d = 1'b0;
        hrst_disc_d = 1'b0;

        // Request capture; clears below take precedence over a same-cycle set.
        if (txsend_req && !pend_msg_q && !in_tx) begin
            pend_msg_d = 1'b1;
        end
        if (txhrst_req && (state_q != S_TX_HRST)) begin
            pend_hrst_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_msg_q || pend_hrst_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pend_hrst_q) begin
                    // Hard reset outranks a queued message, which is dropped.
                    if (pend_msg_q) begin
                        msg_disc_d = 1'b1;
                        pend_msg_d = 1'b0;
                    end
                    if (hrst_rx) begin
                        hrst_disc_d = 1'b1;
                        pend_hrst_d = 1'b0;
                        state_d     = S_IDLE;
                    end else if (gap_ok && !rx_busy) begin
                        pend_hrst_d = 1'b0;
                        state_d     = S_TX_HRST;
                    end
                end else if (pend_msg_q) begin
                    if (rx_busy || hrst_rx) begin
                        msg_disc_d = 1'b1;
                        pend_msg_d = 1'b0;
                        state_d    = S_IDLE;
                    end else if (gap_ok) begin
                        pend_msg_d = 1'b0;
                        state_d    = S_TX_MSG;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TX_MSG: begin
                // A completing message wins over an abort; the hard-reset
                // request stays latched and is served through WAIT.
                if (tx_done) begin
                    msg_sent_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (txhrst_req) begin
                    msg_abt_d   = 1'b1;
                    pend_hrst_d = 1'b0;
                    state_d     = S_TX_HRST;
                end
            end
            S_TX_HRST: begin
                if (tx_done) begin
                    hrst_sent_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disabling the peripheral drops everything silently.
        if (!ucpden) begin
            state_d     = S_IDLE;
            pend_msg_d  = 1'b0;
            pend_hrst_d = 1'b0;
            msg_sent_d  = 1'b0;
            msg_disc_d  = 1'b0;
            msg_abt_d   = 1'b0;
            hrst_sent_d = 1'b0;
            hrst_disc_d = 1'b0;
        end
    end

    always_ff @(posedge ic_clk or posedge ic_rst) begin
        if (ic_rst) begin
            state_q     <= S_IDLE;
            pend_msg_q  <= 1'b0;
            pend_hrst_q <= 1'b0;
            gap_q       <= '0;
            msg_sent_q  <= 1'b0;
            msg_disc_q  <= 1'b0;
            msg_abt_q   <= 1'b0;
            hrst_sent_q <= 1'b0;
            hrst_disc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_msg_q  <= pend_msg_d;
            pend_hrst_q <= pend_hrst_d;
            gap_q       <= gap_d;
            msg_sent_q  <= msg_sent_d;
            msg_disc_q  <= msg_disc_d;
            msg_abt_q   <= msg_abt_d;
            hrst_sent_q <= hrst_sent_d;
            hrst_disc_q <= hrst_disc_d;
        end
    end

    // Enables decode the state register only, keeping them glitch-free.
    assign transmit_en  = (state_q == S_TX_MSG);
    assign tx_hrst      = (state_q == S_TX_HRST);
    assign tx_msg_sent  = msg_sent_q;
    assign tx_msg_disc  = msg_disc_q;
    assign tx_msg_abt   = msg_abt_q;
    assign tx_hrst_sent = hrst_sent_q;
    assign tx_hrst_disc = hrst_disc_q;
    assign sched_busy   = (state_q != S_IDLE) || pend_msg_q || pend_hrst_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_ucpd_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_ucpd_tx_sched
//  Purpose  : Self-checking bench for apb_ucpd_tx_sched. Stimulus pushes the
//             expected output changes (cycle + output vector) into a queue;
//             a monitor pops and compares on every observed output change.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_ucpd_tx_sched;

    logic       ic_clk = 1'b0;
    logic       ic_rst;
    logic       ucpden;
    logic       hbit_clk_red;
    logic [4:0] ifrgap;
    logic       txsend_req;
    logic       txhrst_req;
    logic       rx_busy;
    logic       hrst_rx;
    logic       tx_done;
    logic       transmit_en;
    logic       tx_hrst;
    logic       tx_msg_sent;
    logic       tx_msg_disc;
    logic       tx_msg_abt;
    logic       tx_hrst_sent;
    logic       tx_hrst_disc;
    logic       sched_busy;

    apb_ucpd_tx_sched #(.GAP_W(5)) dut (
        .ic_clk       (ic_clk),
        .ic_rst       (ic_rst),
        .ucpden       (ucpden),
        .hbit_clk_red (hbit_clk_red),
        .ifrgap       (ifrgap),
        .txsend_req   (txsend_req),
        .txhrst_req   (txhrst_req),
        .rx_busy      (rx_busy),
        .hrst_rx      (hrst_rx),
        .tx_done      (tx_done),
        .transmit_en  (transmit_en),
        .tx_hrst      (tx_hrst),
        .tx_msg_sent  (tx_msg_sent),
        .tx_msg_disc  (tx_msg_disc),
        .tx_msg_abt   (tx_msg_abt),
        .tx_hrst_sent (tx_hrst_sent),
        .tx_hrst_disc (tx_hrst_disc),
        .sched_busy   (sched_busy)
    );

    always #5 ic_clk = ~ic_clk;

    // Edge counter: after rising edge n (and until the next one) cyc == n.
    int cyc = 0;
    always @(posedge ic_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int hb_per   = 0;

    // Output vector: {transmit_en, tx_hrst, sent, disc, abt, hrst_sent, hrst_disc}
    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_TXM   = 7'b1000000;
    localparam logic [6:0] V_TXH   = 7'b0100000;
    localparam logic [6:0] V_SENT  = 7'b0010000;
    localparam logic [6:0] V_DISC  = 7'b0001000;
    localparam logic [6:0] V_ABT   = 7'b0100100;
    localparam logic [6:0] V_HSENT = 7'b0000010;
    localparam logic [6:0] V_HDISC = 7'b0000001;
    localparam logic [6:0] V_HDMSG = 7'b0101000;

    typedef struct {
        int         cyc;
        logic [6:0] v;
    } ev_t;

    ev_t q[$];

    logic [6:0] outs;
    logic [6:0] prev = 7'b0;
    assign outs = {transmit_en, tx_hrst, tx_msg_sent, tx_msg_disc,
                   tx_msg_abt, tx_hrst_sent, tx_hrst_disc};

    // Monitor: every change of the output vector is one scoreboard event.
    always @(negedge ic_clk) begin
        ev_t e;
        if (!ic_rst && (outs !== prev)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: cyc=%0d outs=%b, required no change", cyc, outs);
            end else begin
                e = q.pop_front();
                if ((e.cyc != cyc) || (e.v !== outs)) begin
                    failures++;
                    $display("FAIL event: got cyc=%0d outs=%b, required cyc=%0d outs=%b",
                             cyc, outs, e.cyc, e.v);
                end
            end
        end
        prev = outs;
    end

    task automatic exp_ev(input int c, input logic [6:0] v);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Advance one edge; half-bit tick is asserted for edges divisible by hb_per.
    task automatic tick();
        @(posedge ic_clk);
        #1;
        hbit_clk_red = (hb_per != 0) && (((cyc + 1) % hb_per) == 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    int n;

    initial begin
        ic_rst = 1'b1; ucpden = 1'b0; hbit_clk_red = 1'b0; ifrgap = 5'd0;
        txsend_req = 1'b0; txhrst_req = 1'b0; rx_busy = 1'b0;
        hrst_rx = 1'b0; tx_done = 1'b0;
        ticks(3);
        chk("reset_outs", {25'd0, outs}, 32'd0);
        chk("reset_busy", {31'd0, sched_busy}, 32'd0);
        ic_rst = 1'b0;
        ucpden = 1'b1;

        // Basic send with gap already satisfied.
        ifrgap = 5'd4; hb_per = 1;
        ticks(6);
        n = cyc;
        exp_ev(n + 3, V_TXM);
        exp_ev(n + 11, V_SENT);
        exp_ev(n + 12, V_IDLE);
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        chk("busy_after_req", {31'd0, sched_busy}, 32'd1);
        ticks(9);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        ticks(3);

        // Gap enforcement: 8 ticks on even edges after rx_busy falls.
        ifrgap = 5'd8; hb_per = 2;
        rx_busy = 1'b1;
        ticks(2);
        while ((cyc % 2) != 1) tick();
        n = cyc;
        rx_busy = 1'b0;
        tick();
        exp_ev(n + 16, V_TXM);
        exp_ev(n + 19, V_SENT);
        exp_ev(n + 20, V_IDLE);
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        ticks(16);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        hb_per = 0;
        ticks(3);

        // Discard on reception while waiting for the gap.
        n = cyc;
        exp_ev(n + 3, V_DISC);
        exp_ev(n + 4, V_IDLE);
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        tick();
        chk("busy_in_wait", {31'd0, sched_busy}, 32'd1);
        rx_busy = 1'b1; tick(); rx_busy = 1'b0;
        ticks(3);
        chk("idle_after_disc", {31'd0, sched_busy}, 32'd0);

        // Abort; a send request during TX_MSG must be ignored.
        ifrgap = 5'd0;
        n = cyc;
        exp_ev(n + 3, V_TXM);
        exp_ev(n + 6, V_ABT);
        exp_ev(n + 7, V_TXH);
        exp_ev(n + 10, V_HSENT);
        exp_ev(n + 11, V_IDLE);
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        ticks(3);
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        txhrst_req = 1'b1; tick(); txhrst_req = 1'b0;
        ticks(3);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        ticks(4);
        chk("idle_after_abort", {31'd0, sched_busy}, 32'd0);

        // Hard-reset discard by received hard reset.
        ifrgap = 5'd31;
        n = cyc;
        exp_ev(n + 3, V_HDISC);
        exp_ev(n + 4, V_IDLE);
        txhrst_req = 1'b1; tick(); txhrst_req = 1'b0;
        tick();
        hrst_rx = 1'b1; tick(); hrst_rx = 1'b0;
        ticks(3);

        // Simultaneous send + hard reset in IDLE.
        ifrgap = 5'd0;
        n = cyc;
        exp_ev(n + 3, V_HDMSG);
        exp_ev(n + 4, V_TXH);
        exp_ev(n + 7, V_HSENT);
        exp_ev(n + 8, V_IDLE);
        txsend_req = 1'b1; txhrst_req = 1'b1; tick();
        txsend_req = 1'b0; txhrst_req = 1'b0;
        ticks(5);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        ticks(3);

        // tx_done and txhrst_req together in TX_MSG: send completes, then hard reset.
        n = cyc;
        exp_ev(n + 3, V_TXM);
        exp_ev(n + 6, V_SENT);
        exp_ev(n + 7, V_IDLE);
        exp_ev(n + 8, V_TXH);
        exp_ev(n + 10, V_HSENT);
        exp_ev(n + 11, V_IDLE);
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        ticks(4);
        tx_done = 1'b1; txhrst_req = 1'b1; tick();
        tx_done = 1'b0; txhrst_req = 1'b0;
        ticks(3);
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        ticks(3);

        // Peripheral disable during TX_MSG: silent drop.
        n = cyc;
        exp_ev(n + 3, V_TXM);
        exp_ev(n + 6, V_IDLE);
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        ticks(4);
        ucpden = 1'b0; tick();
        chk("busy_after_disable", {31'd0, sched_busy}, 32'd0);
        ucpden = 1'b1;
        ticks(3);

        // Asynchronous reset in WAIT.
        ifrgap = 5'd31;
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        tick();
        chk("busy_before_rst", {31'd0, sched_busy}, 32'd1);
        #2 ic_rst = 1'b1;
        #1;
        chk("rst_wait_busy", {31'd0, sched_busy}, 32'd0);
        chk("rst_wait_outs", {25'd0, outs}, 32'd0);
        ticks(2);
        ic_rst = 1'b0;
        ticks(2);

        // Asynchronous reset in TX_MSG.
        ifrgap = 5'd0;
        n = cyc;
        exp_ev(n + 3, V_TXM);
        txsend_req = 1'b1; tick(); txsend_req = 1'b0;
        ticks(3);
        chk("txm_before_rst", {31'd0, transmit_en}, 32'd1);
        #2 ic_rst = 1'b1;
        #1;
        chk("rst_tx_en", {31'd0, transmit_en}, 32'd0);
        chk("rst_tx_busy", {31'd0, sched_busy}, 32'd0);
        ticks(2);
        ic_rst = 1'b0;
        ticks(2);

        // tx_done in IDLE is ignored.
        tx_done = 1'b1; tick(); tx_done = 1'b0;
        ticks(3);
        chk("done_in_idle", {31'd0, sched_busy}, 32'd0);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d outstanding, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_ucpd_tx_sched.md
# apb_ucpd_tx_sched

Transmit scheduler for the UCPD core. It accepts message-send and hard-reset requests from the register block and enforces the interframe gap against line activity. It arbitrates between a pending message, a pending hard reset and an incoming reception, then drives the core's `transmit_en` / `tx_hrst` strobes. It reports sent, discarded and aborted events back to the status register logic.

## Interface

Parameters:
- `GAP_W`, default 5: width of the interframe-gap counter and of `ifrgap`.

Ports:
- `ic_clk`, in, 1: UCPD kernel clock.
- `ic_rst`, in, 1: asynchronous, active-high reset.
- `ucpden`, in, 1: peripheral enable. Low forces IDLE and clears all pending requests.
- `hbit_clk_red`, in, 1: one-cycle half-bit tick.
- `ifrgap`, in, GAP_W: required idle half-bit ticks before a transmission may start.
- `txsend_req`, in, 1: one-cycle pulse requesting transmission of the message in TXDR/ordset.
- `txhrst_req`, in, 1: one-cycle pulse requesting a hard reset.
- `rx_busy`, in, 1: receiver is not in idle (preamble/SOP/data in progress).
- `hrst_rx`, in, 1: one-cycle pulse, hard reset ordered set received.
- `tx_done`, in, 1: one-cycle pulse, core finished EOP (message) or hard-reset ordered set.
- `transmit_en`, out, 1: core message transmission enable.
- `tx_hrst`, out, 1: core hard-reset transmission enable.
- `tx_msg_sent`, out, 1: pulse.
- `tx_msg_disc`, out, 1: pulse.
- `tx_msg_abt`, out, 1: pulse.
- `tx_hrst_sent`, out, 1: pulse.
- `tx_hrst_disc`, out, 1: pulse.
- `sched_busy`, out, 1: state not IDLE or any request pending.

## Operation

Pending flags `pend_msg` and `pend_hrst`:
- Set on the edge sampling the request pulse.
- Cleared on the edge entering the matching TX state, or on discard.
- A `txsend_req` arriving while `pend_msg` is set or the FSM is in TX_MSG/TX_HRST is ignored.
- A `txhrst_req` arriving while in TX_HRST is ignored.

Gap counter:
- GAP_W bits, saturates at all-ones.
- Cleared while `rx_busy`=1, while in TX_MSG or TX_HRST, and on the `tx_done` edge.
- Otherwise increments on each `hbit_clk_red`.
- `gap_ok` = (count >= `ifrgap`). An `ifrgap` of 0 gives `gap_ok` permanently true outside activity.

FSM states: IDLE, WAIT, TX_MSG, TX_HRST.
- IDLE: any pending flag set → WAIT.
- WAIT, `pend_hrst` set (hard reset has priority):
  - If `pend_msg` is also set, pulse `tx_msg_disc` and clear `pend_msg`.
  - `hrst_rx` → pulse `tx_hrst_disc`, clear `pend_hrst`, go to IDLE.
  - Else `gap_ok` & !`rx_busy` → TX_HRST.
- WAIT, only `pend_msg` set:
  - `rx_busy`=1 or `hrst_rx` → pulse `tx_msg_disc`, clear `pend_msg`, go to IDLE.
  - Else `gap_ok` → TX_MSG.
- TX_MSG:
  - `txhrst_req` → pulse `tx_msg_abt`, go directly to TX_HRST without gap.
  - `tx_done` → pulse `tx_msg_sent`, go to IDLE.
- TX_HRST: `tx_done` → pulse `tx_hrst_sent`, go to IDLE.
- `txhrst_req` in WAIT or IDLE sets `pend_hrst`. It is evaluated by the priority rule on the next cycle.

Outputs:
- `transmit_en` = (state==TX_MSG).
- `tx_hrst` = (state==TX_HRST).
- Both are decoded from the state register only, so they are glitch-free.

`ucpden`=0:
- Synchronously forces IDLE, clears the pending flags and the gap counter.
- Produces no status pulses.
- Any transmission in progress is dropped silently.

## Timing

- Reset: state IDLE, pending flags 0, gap counter 0. Every output is 0.
- Request latency: pulse sampled at edge E0 → WAIT at E1 → TX at E2 if `gap_ok` & idle. The enable is high from E2.
- Abort: `txhrst_req` sampled in TX_MSG at edge E → `tx_msg_abt`=1 and `tx_hrst`=1 for the cycle after E. `transmit_en` falls at E.
- Status pulses are exactly one cycle wide. They are registered at the edge of the triggering transition.
- Simultaneous `tx_done` and `txhrst_req` in TX_MSG: `tx_done` wins. `tx_msg_sent` pulses and `pend_hrst` is set, so a hard reset follows through WAIT.
- Simultaneous `txsend_req` and `txhrst_req` in IDLE: both flags are set. The message is discarded in WAIT and the hard reset proceeds.
- `tx_done` in IDLE or WAIT is ignored.
- Asynchronous `ic_rst` mid-transmission returns everything to reset values immediately.

## Test plan

- Basic send: `ifrgap`=4, line idle ≥4 ticks, `txsend_req` at cycle 10 → `transmit_en` high from cycle 12. `tx_done` at 50 → `tx_msg_sent` pulse at 51 and `transmit_en` low at 51.
- Gap enforcement: `ifrgap`=8, `rx_busy` falls at T, `txsend_req` at T+1. Since `rx_busy` is already low, no discard occurs → `transmit_en` rises only after the 8th `hbit_clk_red` following T.
- Discard on reception: `pend_msg` in WAIT, `rx_busy` rises → one `tx_msg_disc` pulse, state IDLE, `transmit_en` never asserted.
- Abort: in TX_MSG, `txhrst_req` pulse → `tx_msg_abt` pulse plus `tx_hrst` high the next cycle. `tx_done` → `tx_hrst_sent` pulse.
- Hard-reset discard: `ifrgap`=31, `txhrst_req`, then `hrst_rx` during WAIT → `tx_hrst_disc` pulse, `tx_hrst` never high.
- Enable/reset: drop `ucpden` during TX_MSG → `transmit_en` low next cycle with no status pulse. Assert `ic_rst` mid-WAIT → all outputs 0 without waiting for a clock edge.
